// File: rtl/scatter_unit_pkg.sv
// Shared definitions for the scatter network: active-level constants and the
// lane-index width helper used by every file of the block.
package scatter_unit_pkg;

    localparam logic HIGH      = 1'b1;
    localparam logic LOW       = 1'b0;
    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    // Bits needed to hold any count in 0..n inclusive.
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scatter_prefix.sv
// Exclusive prefix popcount of active-high lane enables: o_idx[i] is the
// number of set enables below lane i, o_total the number over all lanes.
module scatter_prefix
    import scatter_unit_pkg::*;
#(
    parameter  int OUT = 8,
    localparam int W   = idx_width(OUT)
) (
    input  logic [OUT-1:0]        i_en,
    output logic [OUT-1:0][W-1:0] o_idx,
    output logic [W-1:0]          o_total
);

    logic [OUT:0][W-1:0] w_run;

    assign w_run[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < OUT; gi++) begin : g_lane
            assign w_run[gi+1] = w_run[gi] + W'(i_en[gi]);
            assign o_idx[gi]   = w_run[gi];
        end
    endgenerate

    assign o_total = w_run[OUT];

endmodule

// File: rtl/scatter_unit.sv
// Registered scatter: packed word k lands on the k-th enabled output lane.
// Optional registered lane count output under SCATTER_UNIT_COUNT_EN.
module scatter_unit
    import scatter_unit_pkg::*;
#(
    parameter int   DATA = 32,
    parameter int   IN   = 8,
    parameter logic ACT  = HIGH,
    parameter int   OUT  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IN-1:0][DATA-1:0]    in,
    input  logic [OUT-1:0]             sel,
    output logic [OUT-1:0]             valid,
    output logic [OUT-1:0][DATA-1:0]   out
`ifdef SCATTER_UNIT_COUNT_EN
    ,
    output logic [idx_width(OUT)-1:0]  count
`endif
);

    localparam int W = idx_width(OUT);

    logic [OUT-1:0]            w_en;
    logic [OUT-1:0][W-1:0]     w_idx;
    logic [W-1:0]              w_total;
    logic                      w_all_fit;
    logic [OUT-1:0][DATA-1:0]  w_out_next;
    logic [OUT-1:0]            w_valid_next;

    logic [OUT-1:0][DATA-1:0]  r_out;
    logic [OUT-1:0]            r_valid;

    assign w_en = (ACT == HIGH) ? sel : ~sel;

    scatter_prefix #(
        .OUT (OUT)
    ) u_prefix (
        .i_en    (w_en),
        .o_idx   (w_idx),
        .o_total (w_total)
    );

    // When every enabled lane has a word, the per-lane supply compare is moot.
    assign w_all_fit = (int'(w_total) <= IN);

    genvar gi;
    generate
        for (gi = 0; gi < OUT; gi++) begin : g_lane
            logic [DATA-1:0] w_word;
            logic            w_fill;

            always_comb begin
                w_word = '0;
                for (int k = 0; k < IN; k++) begin
                    if (int'(w_idx[gi]) == k) begin
                        w_word = in[k];
                    end
                end
            end

            assign w_fill           = w_en[gi] && (w_all_fit || (int'(w_idx[gi]) < IN));
            assign w_out_next[gi]   = w_fill ? w_word : '0;
            assign w_valid_next[gi] = w_fill ? ACT : ~ACT;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= '0;
            r_valid <= {OUT{~ACT}};
        end else begin
            r_out   <= w_out_next;
            r_valid <= w_valid_next;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

`ifdef SCATTER_UNIT_COUNT_EN
    logic [W-1:0] w_count_next;
    logic [W-1:0] r_count;

    // Valid lanes saturate at the number of input words available.
    assign w_count_next = w_all_fit ? w_total : W'(IN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;
`endif

endmodule

// File: tb/tb_scatter_unit.sv
// Bench for scatter_unit: three instances (default, active-low, two-word
// supply) checked against a lane-list reference model.
module tb_scatter_unit;
    import scatter_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    logic [7:0][31:0] in_m, in_l;
    logic [1:0][31:0] in_o;
    logic [7:0]       sel_m, sel_l, sel_o;
    logic [7:0]       valid_m, valid_l, valid_o;
    logic [7:0][31:0] out_m, out_l, out_o;
`ifdef SCATTER_UNIT_COUNT_EN
    logic [3:0]       count_m, count_l, count_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scatter_unit #(.DATA(32), .IN(8), .ACT(HIGH), .OUT(8)) dut_main (
        .clk   (clk),
        .reset (reset),
        .in    (in_m),
        .sel   (sel_m),
        .valid (valid_m),
        .out   (out_m)
`ifdef SCATTER_UNIT_COUNT_EN
        ,
        .count (count_m)
`endif
    );

    scatter_unit #(.DATA(32), .IN(8), .ACT(LOW), .OUT(8)) dut_low (
        .clk   (clk),
        .reset (reset),
        .in    (in_l),
        .sel   (sel_l),
        .valid (valid_l),
        .out   (out_l)
`ifdef SCATTER_UNIT_COUNT_EN
        ,
        .count (count_l)
`endif
    );

    scatter_unit #(.DATA(32), .IN(2), .ACT(HIGH), .OUT(8)) dut_ovf (
        .clk   (clk),
        .reset (reset),
        .in    (in_o),
        .sel   (sel_o),
        .valid (valid_o),
        .out   (out_o)
`ifdef SCATTER_UNIT_COUNT_EN
        ,
        .count (count_o)
`endif
    );

    // Reference: list the enabled lanes, then hand out words in order.
    function automatic void model(input logic [7:0][31:0] din, input logic [7:0] s,
                                  input int n_in, input logic act,
                                  output logic [7:0][31:0] eo, output logic [7:0] ev,
                                  output int cnt);
        int lanes[$];
        eo  = '0;
        ev  = (act == HIGH) ? 8'h00 : 8'hFF;
        cnt = 0;
        for (int i = 0; i < 8; i++)
            if (s[i] == act) lanes.push_back(i);
        for (int k = 0; k < n_in && k < lanes.size(); k++) begin
            eo[lanes[k]] = din[k];
            ev[lanes[k]] = act;
            cnt++;
        end
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++) begin
            in_m[i] = $urandom;
            in_l[i] = $urandom;
        end
        in_o[0] = $urandom;
        in_o[1] = $urandom;
        sel_m = 8'($urandom_range(0, 255));
        sel_l = 8'($urandom_range(0, 255));
        sel_o = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_m"},   out_m,   '0);
        chk({tag, "_valid_m"}, {248'd0, valid_m}, 256'h00);
        chk({tag, "_out_l"},   out_l,   '0);
        chk({tag, "_valid_l"}, {248'd0, valid_l}, 256'hFF);
        chk({tag, "_out_o"},   out_o,   '0);
        chk({tag, "_valid_o"}, {248'd0, valid_o}, 256'h00);
`ifdef SCATTER_UNIT_COUNT_EN
        chk({tag, "_count_m"}, {252'd0, count_m}, 256'd0);
        chk({tag, "_count_l"}, {252'd0, count_l}, 256'd0);
        chk({tag, "_count_o"}, {252'd0, count_o}, 256'd0);
`endif
    endtask

    initial begin
        logic [7:0][31:0] exp_out, pad;
        logic [7:0][31:0] eo_m, eo_l, eo_o;
        logic [7:0]       ev_m, ev_l, ev_o;
        int               ec_m, ec_l, ec_o;

        // Reset held from time zero: outputs must be reset values before any edge.
        reset = 1'b1;
        rand_inputs();
        #2;
        check_reset_state("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_held");
        @(negedge clk);
        reset = 1'b0;

        // Basic scatter
        for (int i = 0; i < 8; i++) in_m[i] = 32'(i + 1);
        sel_m = 8'b0010_0011;
        @(posedge clk); #1;
        exp_out = '0;
        exp_out[0] = 32'd1; exp_out[1] = 32'd2; exp_out[5] = 32'd3;
        chk("basic_out", out_m, exp_out);
        chk("basic_valid", {248'd0, valid_m}, 256'h23);
`ifdef SCATTER_UNIT_COUNT_EN
        chk("basic_count", {252'd0, count_m}, 256'd3);
`endif

        // Full and empty
        for (int i = 0; i < 8; i++) in_m[i] = $urandom;
        sel_m = 8'hFF;
        @(posedge clk); #1;
        chk("full_out", out_m, in_m);
        chk("full_valid", {248'd0, valid_m}, 256'hFF);
        sel_m = 8'h00;
        @(posedge clk); #1;
        chk("empty_out", out_m, '0);
        chk("empty_valid", {248'd0, valid_m}, 256'h00);

        // Active-low and overflow instances
        for (int i = 0; i < 8; i++) in_l[i] = $urandom;
        sel_l = 8'hDC;
        in_o[0] = 32'hA5A5_0001;
        in_o[1] = 32'h5A5A_0002;
        sel_o = 8'h0F;
        @(posedge clk); #1;
        exp_out = '0;
        exp_out[0] = in_l[0]; exp_out[1] = in_l[1]; exp_out[5] = in_l[2];
        chk("low_out", out_l, exp_out);
        chk("low_valid", {248'd0, valid_l}, 256'hDC);
        exp_out = '0;
        exp_out[0] = 32'hA5A5_0001; exp_out[1] = 32'h5A5A_0002;
        chk("ovf_out", out_o, exp_out);
        chk("ovf_valid", {248'd0, valid_o}, 256'h03);
`ifdef SCATTER_UNIT_COUNT_EN
        chk("low_count", {252'd0, count_l}, 256'd3);
        chk("ovf_count", {252'd0, count_o}, 256'd2);
`endif

        // Random transactions with a mid-run asynchronous reset pulse
        for (int t = 0; t < 1000; t++) begin
            if (t == 500) begin
                reset = 1'b1;
                #1;
                check_reset_state("reset_mid");
                reset = 1'b0;
            end
            rand_inputs();
            if (t % 7 == 0) sel_m = 8'hFF;
            if (t % 11 == 0) sel_o = 8'h00;
            pad = '0;
            pad[1:0] = in_o;
            model(in_m, sel_m, 8, HIGH, eo_m, ev_m, ec_m);
            model(in_l, sel_l, 8, LOW,  eo_l, ev_l, ec_l);
            model(pad,  sel_o, 2, HIGH, eo_o, ev_o, ec_o);
            @(posedge clk); #1;
            chk("rand_out_m",   out_m, eo_m);
            chk("rand_valid_m", {248'd0, valid_m}, {248'd0, ev_m});
            chk("rand_out_l",   out_l, eo_l);
            chk("rand_valid_l", {248'd0, valid_l}, {248'd0, ev_l});
            chk("rand_out_o",   out_o, eo_o);
            chk("rand_valid_o", {248'd0, valid_o}, {248'd0, ev_o});
`ifdef SCATTER_UNIT_COUNT_EN
            chk("rand_count_m", {252'd0, count_m}, 256'(ec_m));
            chk("rand_count_l", {252'd0, count_l}, 256'(ec_l));
            chk("rand_count_o", {252'd0, count_o}, 256'(ec_o));
`endif
            if (t < 4 || t == 500)
                $display("txn %0d: sel_m=%02h valid_m=%02h sel_l=%02h valid_l=%02h sel_o=%02h valid_o=%02h",
                         t, sel_m, valid_m, sel_l, valid_l, sel_o, valid_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
